// File: rtl/loader_mem_arbiter_pkg.sv
// Shared definitions for the loader/core memory arbiter: FSM encoding and
// default geometry.
package loader_mem_arbiter_pkg;

    localparam int DEFAULT_ADDRESS_SIZE = 14;
    localparam int DEFAULT_FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADER = 2'd1,
        ST_CORE   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head output, so the arbiter
// can launch the oldest entry in the same cycle it decides to grant it.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign head  = mem[rd_ptr_reg];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/loader_mem_arbiter.sv
// Arbitrates one memory port between buffered bridge-loader byte writes
// (strict priority) and single core accesses.
module loader_mem_arbiter
    import loader_mem_arbiter_pkg::*;
#(
    parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                    clk_74a,
    input  logic                    reset,
    input  logic                    loader_write_en,
    input  logic [ADDRESS_SIZE:0]   loader_write_addr,
    input  logic [7:0]              loader_write_data,
    input  logic                    loading,
    input  logic                    core_req,
    input  logic                    core_wr,
    input  logic [ADDRESS_SIZE:0]   core_addr,
    input  logic [7:0]              core_wr_data,
    output logic                    core_ack,
    output logic [7:0]              core_rd_data,
    output logic                    mem_req,
    output logic                    mem_wr,
    output logic [ADDRESS_SIZE:0]   mem_addr,
    output logic [7:0]              mem_wr_data,
    input  logic                    mem_ack,
    input  logic [7:0]              mem_rd_data,
    output logic                    loader_overflow
);

    localparam int ENTRY_W = ADDRESS_SIZE + 1 + 8;

    arb_state_t           state_reg;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   fifo_head;
    logic                 loader_drop;

    assign fifo_pop    = (state_reg == ST_LOADER) && mem_ack;
    assign loader_drop = loader_write_en && fifo_full && !fifo_pop;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_74a),
        .srst      (reset),
        .push      (loader_write_en),
        .push_data ({loader_write_addr, loader_write_data}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            mem_req         <= 1'b0;
            mem_wr          <= 1'b0;
            mem_addr        <= '0;
            mem_wr_data     <= '0;
            core_ack        <= 1'b0;
            core_rd_data    <= '0;
            loader_overflow <= 1'b0;
        end else begin
            core_ack <= 1'b0;
            if (loader_drop) begin
                loader_overflow <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    // core_ack high means the core has not yet seen its
                    // completion, so its still-high core_req is stale.
                    if (!fifo_empty) begin
                        mem_req     <= 1'b1;
                        mem_wr      <= 1'b1;
                        mem_addr    <= fifo_head[ENTRY_W-1:8];
                        mem_wr_data <= fifo_head[7:0];
                        state_reg   <= ST_LOADER;
                    end else if (core_req && !loading && !core_ack) begin
                        mem_req     <= 1'b1;
                        mem_wr      <= core_wr;
                        mem_addr    <= core_addr;
                        mem_wr_data <= core_wr_data;
                        state_reg   <= ST_CORE;
                    end
                end
                ST_LOADER: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_CORE: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        core_ack  <= 1'b1;
                        state_reg <= ST_IDLE;
                        if (!mem_wr) begin
                            core_rd_data <= mem_rd_data;
                        end
                    end
                end
                default: begin
                    mem_req   <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loader_mem_arbiter.sv
// Directed bench for loader_mem_arbiter with an auto-acking memory model
// and a command log captured on every rising mem_req.
module tb_loader_mem_arbiter;
    import loader_mem_arbiter_pkg::*;

    logic        clk_74a = 1'b0;
    logic        reset;
    logic        loader_write_en;
    logic [14:0] loader_write_addr;
    logic [7:0]  loader_write_data;
    logic        loading;
    logic        core_req;
    logic        core_wr;
    logic [14:0] core_addr;
    logic [7:0]  core_wr_data;
    logic        core_ack;
    logic [7:0]  core_rd_data;
    logic        mem_req;
    logic        mem_wr;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wr_data;
    logic        mem_ack;
    logic [7:0]  mem_rd_data;
    logic        loader_overflow;

    int n_checks = 0;
    int n_errors = 0;

    // memory model controls (main process) and private state (responder)
    int          ack_delay = 2;
    logic        ack_hold  = 1'b0;
    logic [7:0]  rd_value  = 8'h00;
    int          pulse_req = 0;
    int          pulse_seen = 0;
    int          acnt = 0;

    // command log written only by the monitor
    logic        log_wr   [64];
    logic [14:0] log_addr [64];
    logic [7:0]  log_data [64];
    int          cmd_n = 0;
    int          core_ack_n = 0;
    logic        prev_req = 1'b0;

    always #5 clk_74a = ~clk_74a;

    loader_mem_arbiter dut (
        .clk_74a           (clk_74a),
        .reset             (reset),
        .loader_write_en   (loader_write_en),
        .loader_write_addr (loader_write_addr),
        .loader_write_data (loader_write_data),
        .loading           (loading),
        .core_req          (core_req),
        .core_wr           (core_wr),
        .core_addr         (core_addr),
        .core_wr_data      (core_wr_data),
        .core_ack          (core_ack),
        .core_rd_data      (core_rd_data),
        .mem_req           (mem_req),
        .mem_wr            (mem_wr),
        .mem_addr          (mem_addr),
        .mem_wr_data       (mem_wr_data),
        .mem_ack           (mem_ack),
        .mem_rd_data       (mem_rd_data),
        .loader_overflow   (loader_overflow)
    );

    // memory responder: mem_ack sampled ack_delay edges after mem_req rises
    initial begin
        mem_ack     = 1'b0;
        mem_rd_data = 8'h00;
        forever begin
            @(posedge clk_74a);
            #2;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (pulse_req != pulse_seen) begin
                mem_ack    = 1'b1;
                pulse_seen = pulse_req;
            end else if (mem_req && !ack_hold) begin
                if (acnt + 1 >= ack_delay) begin
                    mem_ack     = 1'b1;
                    mem_rd_data = rd_value;
                    acnt        = 0;
                end else begin
                    acnt++;
                end
            end else begin
                acnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_74a);
            #1;
            if (mem_req && !prev_req && cmd_n < 64) begin
                log_wr[cmd_n]   = mem_wr;
                log_addr[cmd_n] = mem_addr;
                log_data[cmd_n] = mem_wr_data;
                cmd_n++;
            end
            prev_req = mem_req;
            if (core_ack) core_ack_n++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_74a);
        #3;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic wait_req(input logic level, input int max_cycles, input string tag);
        int n = 0;
        while (mem_req !== level && n < max_cycles) begin
            tick();
            n++;
        end
        if (mem_req !== level) check_eq({tag, "_timeout"}, 32'(mem_req), 32'(level));
    endtask

    task automatic wait_core_ack(input int max_cycles, input string tag);
        int n = 0;
        while (core_ack !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        if (core_ack !== 1'b1) check_eq({tag, "_timeout"}, 32'(core_ack), 32'd1);
    endtask

    task automatic push_byte(input logic [14:0] a, input logic [7:0] d);
        loader_write_en   = 1'b1;
        loader_write_addr = a;
        loader_write_data = d;
        tick();
        loader_write_en   = 1'b0;
    endtask

    function automatic logic [31:0] cmd_word(input logic w, input logic [14:0] a, input logic [7:0] d);
        return {8'h00, w, a, d};
    endfunction

    initial begin
        int base;
        int hi;
        int n;
        int acks_before;
        logic prev_ack;

        reset = 1'b1;
        loader_write_en = 1'b0; loader_write_addr = '0; loader_write_data = '0;
        loading = 1'b0; core_req = 1'b0; core_wr = 1'b0; core_addr = '0; core_wr_data = '0;

        // reset state
        repeat (3) tick();
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wr_data", 32'(mem_wr_data), 32'd0);
        check_eq("rst_core_ack", 32'(core_ack), 32'd0);
        check_eq("rst_core_rd_data", 32'(core_rd_data), 32'd0);
        check_eq("rst_overflow", 32'(loader_overflow), 32'd0);
        check_eq("rst_fifo_empty", 32'(dut.u_fifo.empty), 32'd1);
        check_eq("rst_state", 32'(dut.state_reg), 32'(ST_IDLE));
        reset = 1'b0;
        tick();

        // single loader write, ack two cycles after mem_req
        base = cmd_n;
        push_byte(15'h0010, 8'hAB);
        wait_req(1'b1, 10, "ldr_req");
        check_eq("ldr_mem_wr", 32'(mem_wr), 32'd1);
        check_eq("ldr_mem_addr", 32'(mem_addr), 32'h0010);
        check_eq("ldr_mem_wr_data", 32'(mem_wr_data), 32'hAB);
        hi = 0;
        while (mem_req && hi < 20) begin
            tick();
            hi++;
        end
        check_eq("ldr_req_cycles", 32'(hi), 32'd2);
        check_eq("ldr_fifo_empty", 32'(dut.u_fifo.empty), 32'd1);
        check_eq("ldr_state_idle", 32'(dut.state_reg), 32'(ST_IDLE));
        check_eq("ldr_cmd_count", 32'(cmd_n - base), 32'd1);

        // core read, held through the core_ack cycle
        rd_value = 8'h5C;
        acks_before = core_ack_n;
        core_req = 1'b1; core_wr = 1'b0; core_addr = 15'h0100; core_wr_data = 8'h00;
        wait_req(1'b1, 10, "crd_req");
        check_eq("crd_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("crd_mem_addr", 32'(mem_addr), 32'h0100);
        prev_ack = 1'b0;
        n = 0;
        while (core_ack !== 1'b1 && n < 20) begin
            prev_ack = mem_ack;
            tick();
            n++;
        end
        check_eq("crd_core_ack", 32'(core_ack), 32'd1);
        check_eq("crd_ack_after_mem_ack", 32'(prev_ack), 32'd1);
        check_eq("crd_rd_data", 32'(core_rd_data), 32'h5C);
        tick();
        core_req = 1'b0;
        check_eq("crd_ack_pulse", 32'(core_ack), 32'd0);
        check_eq("crd_rd_data_held", 32'(core_rd_data), 32'h5C);
        hi = 0;
        repeat (3) begin
            if (mem_req) hi++;
            tick();
        end
        check_eq("crd_no_regrant", 32'(hi), 32'd0);
        check_eq("crd_ack_count", 32'(core_ack_n - acks_before), 32'd1);

        // core write pending while three loader bytes arrive
        base = cmd_n;
        loading = 1'b1;
        core_req = 1'b1; core_wr = 1'b1; core_addr = 15'h0200; core_wr_data = 8'h77;
        for (int i = 0; i < 3; i++) push_byte(15'h0020 + 15'(i), 8'(8'h11 * (i + 1)));
        loading = 1'b0;
        n = 0;
        while (cmd_n - base < 4 && n < 80) begin
            tick();
            n++;
        end
        check_eq("ord_cmd0", cmd_word(log_wr[base], log_addr[base], log_data[base]), cmd_word(1'b1, 15'h0020, 8'h11));
        check_eq("ord_cmd1", cmd_word(log_wr[base+1], log_addr[base+1], log_data[base+1]), cmd_word(1'b1, 15'h0021, 8'h22));
        check_eq("ord_cmd2", cmd_word(log_wr[base+2], log_addr[base+2], log_data[base+2]), cmd_word(1'b1, 15'h0022, 8'h33));
        check_eq("ord_cmd3", cmd_word(log_wr[base+3], log_addr[base+3], log_data[base+3]), cmd_word(1'b1, 15'h0200, 8'h77));
        wait_core_ack(20, "ord_core_ack");
        core_req = 1'b0;
        tick();

        // overflow: five consecutive pushes with mem_ack withheld
        ack_hold = 1'b1;
        base = cmd_n;
        for (int i = 0; i < 5; i++) push_byte(15'h0030 + 15'(i), 8'hA0 + 8'(i));
        check_eq("ovf_flag", 32'(loader_overflow), 32'd1);
        check_eq("ovf_count", 32'(dut.u_fifo.count_reg), 32'd4);
        check_eq("ovf_req_held", 32'(mem_req), 32'd1);
        repeat (5) tick();
        check_eq("ovf_flag_sticky", 32'(loader_overflow), 32'd1);
        check_eq("ovf_addr_stable", 32'(mem_addr), 32'h0030);
        ack_hold = 1'b0;
        n = 0;
        while ((cmd_n - base < 4 || mem_req) && n < 80) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check_eq("ovf_cmd_count", 32'(cmd_n - base), 32'd4);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("ovf_cmd%0d", i), cmd_word(log_wr[base+i], log_addr[base+i], log_data[base+i]),
                     cmd_word(1'b1, 15'h0030 + 15'(i), 8'hA0 + 8'(i)));
        check_eq("ovf_fifo_empty", 32'(dut.u_fifo.empty), 32'd1);
        check_eq("ovf_flag_after_drain", 32'(loader_overflow), 32'd1);

        // loading blocks the core for 20 cycles, grant one cycle after it falls
        ack_delay = 3;
        rd_value = 8'h3C;
        loading = 1'b1;
        core_req = 1'b1; core_wr = 1'b0; core_addr = 15'h0300;
        hi = 0;
        repeat (20) begin
            tick();
            if (mem_req) hi++;
        end
        check_eq("blk_no_grant", 32'(hi), 32'd0);
        loading = 1'b0;
        n = 0;
        while (!mem_req && n < 10) begin
            tick();
            n++;
        end
        check_eq("blk_grant_latency", 32'(n), 32'd1);
        check_eq("blk_mem_addr", 32'(mem_addr), 32'h0300);
        wait_core_ack(20, "blk_core_ack");
        check_eq("blk_rd_data", 32'(core_rd_data), 32'h3C);
        core_req = 1'b0;
        tick();
        tick();

        // reset in the middle of a core access, then a stray mem_ack
        ack_hold = 1'b1;
        core_req = 1'b1; core_wr = 1'b1; core_addr = 15'h0400; core_wr_data = 8'h99;
        wait_req(1'b1, 10, "mrst_req");
        acks_before = core_ack_n;
        tick();
        reset = 1'b1;
        core_req = 1'b0;
        tick();
        reset = 1'b0;
        check_eq("mrst_mem_req", 32'(mem_req), 32'd0);
        check_eq("mrst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("mrst_overflow", 32'(loader_overflow), 32'd0);
        check_eq("mrst_state", 32'(dut.state_reg), 32'(ST_IDLE));
        pulse_req++;
        repeat (4) tick();
        check_eq("mrst_no_core_ack", 32'(core_ack_n - acks_before), 32'd0);
        check_eq("mrst_mem_req_after", 32'(mem_req), 32'd0);
        check_eq("mrst_state_after", 32'(dut.state_reg), 32'(ST_IDLE));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
